hp_class: RTL and testbench
===========================

// Module: hp_class
// PURPOSE
// - Classifies an IEEE 754 binary16 (half-precision) operand into exactly one of six
//   classes: sNaN, qNaN, infinity, zero, subnormal, normal.
// - Registered, single-cycle-latency front end for half-precision FP datapaths.
// - Optionally keeps per-class occurrence counters for coverage and statistics.
// PARAMETERS
// - CNT_W   16   width of each per-class statistics counter (used only with HP_CLASS_STATS_EN)
// PORTS
// - clk        in   1      single clock; all state updates on rising edge
// - rst_n      in   1      asynchronous, active-low reset
// - f          in   16     binary16 operand {sign[15], exp[14:10], frac[9:0]}
// - in_valid   in   1      f is sampled when high
// - snan       out  1      signalling NaN: exp=5'h1F, frac!=0, frac[9]=0
// - qnan       out  1      quiet NaN: exp=5'h1F, frac[9]=1
// - infinity   out  1      exp=5'h1F, frac=0
// - zero       out  1      exp=0, frac=0
// - subnormal  out  1      exp=0, frac!=0
// - normal     out  1      exp in 1..30
// - out_valid  out  1      class flags correspond to the sample taken the previous cycle
// - stats_clr  in   1      synchronous clear of all counters (HP_CLASS_STATS_EN only)
// - cnt_snan, cnt_qnan, cnt_inf, cnt_zero, cnt_sub, cnt_norm  out  CNT_W each
//              per-class counts (HP_CLASS_STATS_EN only)
// BEHAVIOUR
// - Reset (rst_n=0, async): all six class flags 0, out_valid 0, all counters 0.
// - Decode is combinational from f; sign bit is ignored for classification.
// - Latency 1 cycle: in_valid=1 at edge N -> flags and out_valid=1 visible after edge N.
// - in_valid=0 at an edge: out_valid goes 0; class flags hold their last values.
// - After reset, until the first valid sample, all flags are 0 (the only time none is set).
// - Once any sample is taken, exactly one flag is 1 (one-hot); never two at once.
// - No backpressure: a new sample is accepted every cycle that in_valid=1.
// - Reset asserted mid-stream clears the outputs immediately; the in-flight sample is lost.
// CONFIGURATION
// - Macro HP_CLASS_STATS_EN:
//   defined: the six counters exist; each increments by 1 at every edge where in_valid=1
//   and the decoded class matches; saturates at all-ones (no wrap). stats_clr=1 zeroes
//   all counters at the edge and takes priority: a sample accepted in the same cycle is
//   not counted. Counters update in step with the flags (visible the same cycle).
//   undefined: no counters, stats_clr and cnt_* ports absent; flag logic unchanged.
// TESTING
// - f=16'h0000 and 16'h8000 -> zero=1 only; f=16'h7C00 and 16'hFC00 -> infinity=1 only.
// - f=16'h7E00 -> qnan; f=16'h7C01 -> snan; f=16'h0001 and 16'h03FF -> subnormal;
//   f=16'h0400, 16'h3C00, 16'h7BFF -> normal.
// - Sweep all 65536 codes with in_valid=1 every cycle -> one-hot each cycle; totals
//   sNaN 1022, qNaN 1024, inf 2, zero 2, subnormal 2046, normal 61440 (sum 65536);
//   with HP_CLASS_STATS_EN the counters read these values at sweep end.
// - Latency/hold: valid 16'h3C00, then in_valid=0 -> normal=1 one cycle later with
//   out_valid=1, then out_valid=0 while normal stays 1.
// - Reset: assert rst_n=0 asynchronously mid-sweep -> all flags, out_valid and
//   counters go 0 without waiting for a clock edge.
// - Stats: stats_clr=1 with valid 16'h0000 -> cnt_zero=0; 2^CNT_W+5 normals ->
//   cnt_norm saturates at all-ones.

Source files
------------

// File: rtl/hp_class.sv
// hp_class: registered IEEE 754 binary16 classifier (sNaN/qNaN/inf/zero/subnormal/normal).
// Define HP_CLASS_STATS_EN to add saturating per-class occurrence counters and stats_clr.
module hp_class #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      f,
    input  logic             in_valid,
    output logic             snan,
    output logic             qnan,
    output logic             infinity,
    output logic             zero,
    output logic             subnormal,
    output logic             normal,
    output logic             out_valid
`ifdef HP_CLASS_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] cnt_snan,
    output logic [CNT_W-1:0] cnt_qnan,
    output logic [CNT_W-1:0] cnt_inf,
    output logic [CNT_W-1:0] cnt_zero,
    output logic [CNT_W-1:0] cnt_sub,
    output logic [CNT_W-1:0] cnt_norm
`endif
);

    logic       exp_ones;
    logic       exp_zero;
    logic       frac_zero;
    logic [5:0] class_d;
    logic [5:0] flags_q;
    logic       valid_q;

    // Class vector bit order: {snan, qnan, inf, zero, subnormal, normal}; sign f[15] is ignored.
    always_comb begin
        exp_ones  = &f[14:10];
        exp_zero  = ~|f[14:10];
        frac_zero = ~|f[9:0];
        class_d   = '0;
        class_d[5] = exp_ones & ~frac_zero & ~f[9];
        class_d[4] = exp_ones & f[9];
        class_d[3] = exp_ones & frac_zero;
        class_d[2] = exp_zero & frac_zero;
        class_d[1] = exp_zero & ~frac_zero;
        class_d[0] = ~exp_ones & ~exp_zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                flags_q <= class_d;
            end
        end
    end

    assign snan      = flags_q[5];
    assign qnan      = flags_q[4];
    assign infinity  = flags_q[3];
    assign zero      = flags_q[2];
    assign subnormal = flags_q[1];
    assign normal    = flags_q[0];
    assign out_valid = valid_q;

`ifdef HP_CLASS_STATS_EN
    logic [CNT_W-1:0] cnt_q [6];
    logic             unused_sign;

    assign unused_sign = f[15];

    // stats_clr wins over a same-cycle sample; counters stop at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 6; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (stats_clr) begin
            for (int unsigned i = 0; i < 6; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (in_valid) begin
            for (int unsigned i = 0; i < 6; i++) begin
                if (class_d[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign cnt_snan = cnt_q[5];
    assign cnt_qnan = cnt_q[4];
    assign cnt_inf  = cnt_q[3];
    assign cnt_zero = cnt_q[2];
    assign cnt_sub  = cnt_q[1];
    assign cnt_norm = cnt_q[0];
`else
    // Sign bit and counter width have no consumer without the statistics block.
    logic unused_cfg;
    assign unused_cfg = f[15] ^ (CNT_W == 0);
`endif

endmodule

// File: tb/tb_hp_class.sv
// Scoreboard bench for hp_class: directed codes, full 16-bit sweep, saturation, random, async reset.
module tb_hp_class;

    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] f;
    logic        in_valid;
    logic        snan, qnan, infinity, zero, subnormal, normal, out_valid;
`ifdef HP_CLASS_STATS_EN
    logic             stats_clr;
    logic [CNT_W-1:0] cnt_snan, cnt_qnan, cnt_inf, cnt_zero, cnt_sub, cnt_norm;
`endif

    hp_class #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .f         (f),
        .in_valid  (in_valid),
        .snan      (snan),
        .qnan      (qnan),
        .infinity  (infinity),
        .zero      (zero),
        .subnormal (subnormal),
        .normal    (normal),
        .out_valid (out_valid)
`ifdef HP_CLASS_STATS_EN
        ,
        .stats_clr (stats_clr),
        .cnt_snan  (cnt_snan),
        .cnt_qnan  (cnt_qnan),
        .cnt_inf   (cnt_inf),
        .cnt_zero  (cnt_zero),
        .cnt_sub   (cnt_sub),
        .cnt_norm  (cnt_norm)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                  vld;
        logic [5:0]            flags;
        logic [5:0][CNT_W-1:0] cnt;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    logic [5:0] last_flags = '0;
    int         mcnt[6];
    int         tally[6];

    // Reference classification: index 5 sNaN, 4 qNaN, 3 inf, 2 zero, 1 subnormal, 0 normal.
    function automatic int ref_class(input logic [15:0] x);
        int e, m;
        e = (int'(x) / 1024) % 32;
        m = int'(x) % 1024;
        if (e == 31) begin
            if (m == 0) return 3;
            if (m >= 512) return 4;
            return 5;
        end
        if (e == 0) return (m == 0) ? 2 : 1;
        return 0;
    endfunction

    function automatic logic [5:0] dut_flags();
        return {snan, qnan, infinity, zero, subnormal, normal};
    endfunction

    function automatic logic [5:0][CNT_W-1:0] dut_cnt();
`ifdef HP_CLASS_STATS_EN
        return {cnt_snan, cnt_qnan, cnt_inf, cnt_zero, cnt_sub, cnt_norm};
`else
        return '0;
`endif
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] x, input logic clr);
        exp_t e;
        int   c;
        @(negedge clk);
        #1;
        in_valid = v;
        f        = x;
        c        = ref_class(x);
        if (v) last_flags = 6'(1 << c);
`ifdef HP_CLASS_STATS_EN
        stats_clr = clr;
        if (clr) begin
            for (int i = 0; i < 6; i++) mcnt[i] = 0;
        end else if (v && mcnt[c] < CMAX) begin
            mcnt[c]++;
        end
`else
        if (clr) c = c;
`endif
        e.vld   = v;
        e.flags = last_flags;
        for (int i = 0; i < 6; i++) e.cnt[i] = mcnt[i][CNT_W-1:0];
        q.push_back(e);
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && q.size() != 0; k++) @(posedge clk);
        #3;
        chk("scoreboard_drain", 128'(q.size()), 128'(0));
    endtask

    function automatic logic [15:0] rand_code();
        int sel;
        sel = $urandom_range(0, 3);
        if (sel == 0) return {1'($urandom), 5'h1F, 10'($urandom)};
        if (sel == 1) return {1'($urandom), 5'h00, 10'($urandom)};
        if (sel == 2) return {1'($urandom), 5'h1F, 10'($urandom_range(0, 1))};
        return 16'($urandom);
    endfunction

    // Monitor: compares one scoreboard entry per cycle, 2 time units after the rising edge.
    initial begin
        exp_t       e;
        logic [5:0] g;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                g = dut_flags();
                chk("valid_flags", {out_valid, g}, {e.vld, e.flags});
`ifdef HP_CLASS_STATS_EN
                chk("counters", dut_cnt(), e.cnt);
`endif
                if (out_valid) begin
                    for (int i = 0; i < 6; i++) if (g[i]) tally[i]++;
                end
            end
        end
    end

    initial begin
        logic [15:0] directed [11];
        directed = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'h7C01,
                     16'h0001, 16'h03FF, 16'h0400, 16'h3C00, 16'h7BFF};
        for (int i = 0; i < 6; i++) begin mcnt[i] = 0; tally[i] = 0; end
        rst_n    = 1'b0;
        in_valid = 1'b0;
        f        = '0;
`ifdef HP_CLASS_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", {out_valid, dut_flags()}, 7'b0);
        chk("reset_counters", dut_cnt(), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        drive(0, 16'h3C00, 0);
        drive(0, 16'h0000, 0);
        foreach (directed[i]) drive(1, directed[i], 0);

        // Latency then hold: flags stay while out_valid drops.
        drive(1, 16'h3C00, 0);
        drive(0, 16'h0001, 0);
        drive(0, 16'h7C00, 0);

        repeat (3) drive(1, 16'h0000, 0);
        drive(1, 16'h0000, 1);
        drive(1, 16'h8000, 0);
        drive(0, 16'h0000, 1);
        drain();

        for (int i = 0; i < 6; i++) tally[i] = 0;
        drive(0, 16'h0000, 1);
        for (int i = 0; i < 65536; i++) drive(1, 16'(i), 0);
        drive(0, 16'h0000, 0);
        drain();
        chk("sweep_snan", 128'(tally[5]), 128'(1022));
        chk("sweep_qnan", 128'(tally[4]), 128'(1024));
        chk("sweep_inf",  128'(tally[3]), 128'(2));
        chk("sweep_zero", 128'(tally[2]), 128'(2));
        chk("sweep_sub",  128'(tally[1]), 128'(2046));
        chk("sweep_norm", 128'(tally[0]), 128'(61440));
`ifdef HP_CLASS_STATS_EN
        chk("sweep_counters", dut_cnt(),
            {16'd1022, 16'd1024, 16'd2, 16'd2, 16'd2046, 16'd61440});
`endif

        // 61440 + 4101 = 2^16 + 5 normals since the last clear.
        for (int i = 0; i < 4101; i++)
            drive(1, {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)}, 0);
        drain();
`ifdef HP_CLASS_STATS_EN
        chk("cnt_norm_saturated", 128'(cnt_norm), 128'(16'hFFFF));
`endif

        for (int i = 0; i < 3000; i++)
            drive($urandom_range(0, 3) != 0, rand_code(), $urandom_range(0, 63) == 0);

        for (int i = 0; i < 5; i++) drive(1, 16'h7E00, 0);
        @(posedge clk);
        #3;
        in_valid = 1'b1;
        f        = 16'h3C00;
        rst_n    = 1'b0;
        #1;
        chk("async_reset_outputs", {out_valid, dut_flags()}, 7'b0);
        chk("async_reset_counters", dut_cnt(), 128'(0));
        @(posedge clk);
        #2;
        chk("reset_blocks_sample", {out_valid, dut_flags()}, 7'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        q.delete();
        last_flags = '0;
        for (int i = 0; i < 6; i++) mcnt[i] = 0;
        drive(0, 16'h7C01, 0);
        drive(1, 16'h7C01, 0);
        drive(1, 16'h0200, 0);
        drive(0, 16'h0000, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
